// File: rtl/wb_pkg.sv
// Shared types, load-type encodings and the load data formatter for the
// regfile_wb writeback stage.
package wb_pkg;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // Byte offset bit 0 is ignored for halfword loads; unknown funct3 passes the word.
  function automatic logic [31:0] ld_format(input logic [31:0] word,
                                            input logic [2:0]  funct3,
                                            input logic [1:0]  byte_off);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    case (byte_off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'h0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'h0, half_sel};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous FIFO of formatted load results; LQ_DEPTH must be a power of two.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(LQ_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: only entries counted as valid are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/regfile_wb.sv
// Writeback stage owning the register file write port: merges ALU and load
// results with starvation-bounded arbitration. Define REGFILE_WB_FWD_EN to add
// the combinational rs1/rs2 bypass from the registered write port.
module regfile_wb
  import wb_pkg::*;
#(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef REGFILE_WB_FWD_EN
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
`endif
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_addr_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        ld_valid_i,
  input  logic [4:0]  ld_rd_addr_i,
  input  logic [31:0] ld_rdata_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_byte_off_i,
  output logic        ld_ready_o,
  output logic        rd_wren_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o
);

  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  wb_entry_t           ld_entry;
  wb_entry_t           lq_head;
  wb_entry_t           hold_entry;
  wb_entry_t           sel_entry;
  logic                lq_full;
  logic                lq_empty;
  logic                hold_valid;
  logic                alu_win;
  logic                lq_win;
  logic                sel_valid;
  logic                alu_accept;
  logic                ld_accept;
  logic [STARVE_W-1:0] starve_cnt;

  // Loads are formatted before they enter the queue so the head is write-ready.
  always_comb begin
    ld_entry.rd   = ld_rd_addr_i;
    ld_entry.data = ld_format(ld_rdata_i, ld_funct3_i, ld_byte_off_i);
  end

  wb_load_fifo #(
    .LQ_DEPTH(LQ_DEPTH)
  ) u_load_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (ld_accept),
    .push_entry(ld_entry),
    .pop       (lq_win),
    .head      (lq_head),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  // The load queue wins by default; a starved ALU hold takes the slot.
  always_comb begin
    alu_win     = hold_valid && (lq_empty || (starve_cnt == STARVE_W'(STARVE_MAX)));
    lq_win      = !lq_empty && !alu_win;
    sel_valid   = alu_win || lq_win;
    sel_entry   = alu_win ? hold_entry : lq_head;
    alu_ready_o = !rst_i && (!hold_valid || alu_win);
    ld_ready_o  = !rst_i && !lq_full;
    alu_accept  = alu_valid_i && alu_ready_o;
    ld_accept   = ld_valid_i && ld_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      hold_entry <= '0;
    end else if (alu_accept) begin
      hold_valid      <= 1'b1;
      hold_entry.rd   <= alu_rd_addr_i;
      hold_entry.data <= alu_data_i;
    end else if (alu_win) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !hold_valid || alu_win) begin
      starve_cnt <= '0;
    end else if (lq_win) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Writes to x0 still occupy the slot but never assert the write enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_wren_o <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else if (sel_valid) begin
      rd_wren_o <= (sel_entry.rd != 5'd0);
      rd_addr_o <= sel_entry.rd;
      rd_data_o <= sel_entry.data;
    end else begin
      rd_wren_o <= 1'b0;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  always_comb begin
    rs1_data_o = rs1_data_i;
    rs2_data_o = rs2_data_i;
    if (rd_wren_o && (rd_addr_o == rs1_addr_i) && (rs1_addr_i != 5'd0)) rs1_data_o = rd_data_o;
    if (rd_wren_o && (rd_addr_o == rs2_addr_i) && (rs2_addr_i != 5'd0)) rs2_data_o = rd_data_o;
  end
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: per-path expected queues filled on handshake,
// drained by an independent write-port monitor.
`timescale 1ns/1ps
module tb_regfile_wb;

  localparam int LQ_DEPTH   = 2;
  localparam int STARVE_MAX = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_rd_addr_i = '0;
  logic [31:0] alu_data_i = '0;
  logic        alu_ready_o;
  logic        ld_valid_i = 1'b0;
  logic [4:0]  ld_rd_addr_i = '0;
  logic [31:0] ld_rdata_i = '0;
  logic [2:0]  ld_funct3_i = '0;
  logic [1:0]  ld_byte_off_i = '0;
  logic        ld_ready_o;
  logic        rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]  rs1_addr_i = '0;
  logic [4:0]  rs2_addr_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
`endif

  regfile_wb #(
    .LQ_DEPTH  (LQ_DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
`ifdef REGFILE_WB_FWD_EN
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .rs1_data_o   (rs1_data_o),
    .rs2_data_o   (rs2_data_o),
`endif
    .alu_valid_i  (alu_valid_i),
    .alu_rd_addr_i(alu_rd_addr_i),
    .alu_data_i   (alu_data_i),
    .alu_ready_o  (alu_ready_o),
    .ld_valid_i   (ld_valid_i),
    .ld_rd_addr_i (ld_rd_addr_i),
    .ld_rdata_i   (ld_rdata_i),
    .ld_funct3_i  (ld_funct3_i),
    .ld_byte_off_i(ld_byte_off_i),
    .ld_ready_o   (ld_ready_o),
    .rd_wren_o    (rd_wren_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_o    (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [36:0] aluExp[$];
  logic [36:0] ldExp[$];
  logic [4:0]  wrLog[$];
  logic [31:0] aluRdMask = 32'hFFFF_0000;
  logic [31:0] ldExpData = '0;
  logic [36:0] monExp;
  logic        aluAcc = 1'b0;
  logic        ldAcc = 1'b0;
  bit          stallWatch = 1'b0;
  int          stallSeen = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic failNow(input string name, input logic [63:0] actual);
    checkCount++;
    $display("[TB] FAIL %s: got %0h, expected nothing", name, actual);
  endtask

  // Load formatting derived directly from the RISC-V load semantics.
  function automatic logic [31:0] refFormat(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return ((b & 32'h80) != 0) ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return ((h & 32'h8000) != 0) ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aData,
                               input logic lV, input logic [4:0] lRd, input logic [31:0] lWord,
                               input logic [2:0] lF3, input logic [1:0] lOff, input logic [31:0] lExp);
    alu_valid_i   = aV;
    alu_rd_addr_i = aRd;
    alu_data_i    = aData;
    ld_valid_i    = lV;
    ld_rd_addr_i  = lRd;
    ld_rdata_i    = lWord;
    ld_funct3_i   = lF3;
    ld_byte_off_i = lOff;
    ldExpData     = lExp;
  endtask

  task automatic applyIdle();
    alu_valid_i = 1'b0;
    ld_valid_i  = 1'b0;
  endtask

  // One clock: record handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clk_i);
    aluAcc = alu_valid_i && alu_ready_o;
    ldAcc  = ld_valid_i && ld_ready_o;
    if (aluAcc && alu_rd_addr_i != 5'd0) aluExp.push_back({alu_rd_addr_i, alu_data_i});
    if (ldAcc && ld_rd_addr_i != 5'd0) ldExp.push_back({ld_rd_addr_i, ldExpData});
    if (stallWatch && ld_valid_i && !ld_ready_o) begin
      stallSeen++;
      checkOutput("lq_full_when_stalled", 64'(ldExp.size() >= LQ_DEPTH), 64'(1));
    end
    @(posedge clk_i);
    #1;
    if (rst_i) begin
      aluExp.delete();
      ldExp.delete();
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    applyIdle();
    while ((aluExp.size() != 0 || ldExp.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput(name, 64'(aluExp.size() + ldExp.size()), 64'(0));
    repeat (2) tick();
  endtask

  task automatic driveBoth(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (c == 0 || aluAcc) begin
        alu_valid_i   = 1'b1;
        alu_rd_addr_i = 5'd2;
        alu_data_i    = $urandom;
      end
      if (c == 0 || ldAcc) begin
        ld_valid_i    = 1'b1;
        ld_rd_addr_i  = 5'd1;
        ld_rdata_i    = $urandom;
        ld_funct3_i   = 3'b010;
        ld_byte_off_i = 2'($urandom_range(0, 3));
        ldExpData     = refFormat(ld_rdata_i, ld_funct3_i, ld_byte_off_i);
      end
      tick();
    end
  endtask

  // Monitor: every write must match the head of the queue for its path.
  always @(negedge clk_i) begin
    if (rd_wren_o === 1'b1) begin
      wrLog.push_back(rd_addr_o);
      if (aluRdMask[rd_addr_o]) begin
        if (aluExp.size() == 0) failNow("alu_unexpected_write", 64'({rd_addr_o, rd_data_o}));
        else begin
          monExp = aluExp.pop_front();
          checkOutput("alu_write", 64'({rd_addr_o, rd_data_o}), 64'(monExp));
        end
      end else begin
        if (ldExp.size() == 0) failNow("ld_unexpected_write", 64'({rd_addr_o, rd_data_o}));
        else begin
          monExp = ldExp.pop_front();
          checkOutput("ld_write", 64'({rd_addr_o, rd_data_o}), 64'(monExp));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    failNow("global_timeout", 64'(0));
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int r;
    int logSize;
    bit seen;

    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_wren", 64'(rd_wren_o), 64'(0));
    checkOutput("reset_addr", 64'(rd_addr_o), 64'(0));
    checkOutput("reset_data", 64'(rd_data_o), 64'(0));
    checkOutput("reset_alu_ready", 64'(alu_ready_o), 64'(0));
    checkOutput("reset_ld_ready", 64'(ld_ready_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_reset_alu_ready", 64'(alu_ready_o), 64'(1));
    checkOutput("post_reset_ld_ready", 64'(ld_ready_o), 64'(1));
    @(posedge clk_i);
    #1;

    $display("[TB] directed load formatting");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h80FF_7F01, 3'b000, 2'd2, 32'hFFFF_FFFF);
    tick();
    checkOutput("lb_accept", 64'(ldAcc), 64'(1));
    waitDrain("lb_write_done", 4);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h80FF_7F01, 3'b100, 2'd2, 32'h0000_00FF);
    tick();
    checkOutput("lbu_accept", 64'(ldAcc), 64'(1));
    waitDrain("lbu_write_done", 4);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h80FF_7F01, 3'b001, 2'd3, 32'hFFFF_80FF);
    tick();
    checkOutput("lh_accept", 64'(ldAcc), 64'(1));
    waitDrain("lh_write_done", 4);

    $display("[TB] ALU write to x0");
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 3'b010, 2'd0, 32'h0);
    tick();
    checkOutput("alu_rd0_accept", 64'(aluAcc), 64'(1));
    applyIdle();
    logSize = wrLog.size();
    repeat (4) tick();
    checkOutput("alu_rd0_no_write", 64'(wrLog.size() - logSize), 64'(0));
    checkOutput("alu_rd0_consumed", 64'(alu_ready_o), 64'(1));

    $display("[TB] contended arbitration");
    aluRdMask  = 32'h0000_0004;
    wrLog.delete();
    stallWatch = 1'b1;
    stallSeen  = 0;
    driveBoth(20);
    stallWatch = 1'b0;
    waitDrain("arb_drain", 10);
    checkOutput("arb_log_len", 64'(wrLog.size() >= 16), 64'(1));
    for (int i = 0; i < 16; i++) begin
      if (i < wrLog.size()) checkOutput("arb_pattern", 64'(wrLog[i]), 64'((i % 4 == 3) ? 2 : 1));
    end
    checkOutput("ld_stall_seen", 64'(stallSeen > 0), 64'(1));

    $display("[TB] reset with queued work");
    driveBoth(5);
    rst_i = 1'b1;
    applyIdle();
    @(negedge clk_i);
    checkOutput("midreset_alu_ready", 64'(alu_ready_o), 64'(0));
    checkOutput("midreset_ld_ready", 64'(ld_ready_o), 64'(0));
    @(posedge clk_i);
    #1;
    aluExp.delete();
    ldExp.delete();
    rst_i = 1'b0;
    wrLog.delete();
    @(negedge clk_i);
    checkOutput("after_reset_wren", 64'(rd_wren_o), 64'(0));
    checkOutput("after_reset_alu_ready", 64'(alu_ready_o), 64'(1));
    checkOutput("after_reset_ld_ready", 64'(ld_ready_o), 64'(1));
    @(posedge clk_i);
    #1;
    repeat (6) tick();
    checkOutput("discarded_never_written", 64'(wrLog.size()), 64'(0));

    $display("[TB] randomized traffic");
    aluRdMask = 32'hFFFF_0000;
    for (int c = 0; c < 300; c++) begin
      if (!alu_valid_i || aluAcc) begin
        alu_valid_i   = ($urandom_range(0, 3) != 0);
        r             = int'($urandom_range(0, 16));
        alu_rd_addr_i = (r == 0) ? 5'd0 : 5'(15 + r);
        alu_data_i    = $urandom;
      end
      if (!ld_valid_i || ldAcc) begin
        ld_valid_i    = ($urandom_range(0, 3) != 0);
        ld_rd_addr_i  = 5'($urandom_range(0, 15));
        ld_rdata_i    = $urandom;
        ld_funct3_i   = 3'($urandom_range(0, 7));
        ld_byte_off_i = 2'($urandom_range(0, 3));
        ldExpData     = refFormat(ld_rdata_i, ld_funct3_i, ld_byte_off_i);
      end
      tick();
    end
    waitDrain("random_drain", 20);

`ifdef REGFILE_WB_FWD_EN
    $display("[TB] forwarding");
    aluRdMask  = 32'h0000_0080;
    rs1_addr_i = 5'd7;
    rs1_data_i = 32'h0;
    rs2_addr_i = 5'd3;
    rs2_data_i = 32'h5555_5555;
    applyStimulus(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 3'b010, 2'd0, 32'h0);
    tick();
    applyIdle();
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      if (rd_wren_o === 1'b1 && rd_addr_o == 5'd7) begin
        seen = 1'b1;
        checkOutput("fwd_rs1_hit", 64'(rs1_data_o), 64'(32'hDEAD_BEEF));
        checkOutput("fwd_rs2_miss", 64'(rs2_data_o), 64'(32'h5555_5555));
        rs1_addr_i = 5'd0;
        rs1_data_i = 32'h1111_2222;
        #1;
        checkOutput("fwd_rs1_x0", 64'(rs1_data_o), 64'(32'h1111_2222));
      end else begin
        tick();
      end
    end
    if (!seen) failNow("fwd_write_timeout", 64'(0));
    waitDrain("fwd_drain", 4);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
